// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - instruction prefetch queue between a variable-latency ROM and decode
module inst_prefetch #(
    parameter int DEPTH = 4,
    parameter int IW    = 9,
    parameter int AW    = 16,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    input  logic          halt,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_target,
    output logic          rom_req,
    output logic [AW-1:0] rom_addr,
    input  logic          rom_valid,
    input  logic [IW-1:0] rom_data,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr_out,
    output logic [AW-1:0] instr_pc,
    output logic [CW-1:0] fill,
    output logic          busy
);

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        IDLE    = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t              state;
    logic [AW-1:0]       fpc;
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic [AW+IW-1:0]    mem [DEPTH];

    logic flush;
    logic push;
    logic pop;

    assign flush       = start | redirect;
    assign push        = (state == WAIT) & rom_valid & ~flush;
    assign pop         = instr_valid & instr_ready & ~flush;

    assign rom_req     = (state == IDLE) & (count < FULL) & ~halt & ~redirect & ~start;
    assign rom_addr    = fpc;
    assign instr_valid = (count != '0);
    // Gate the head so outputs read zero while empty, including during reset.
    assign {instr_pc, instr_out} = instr_valid ? mem[head] : '0;
    assign fill        = count;
    assign busy        = (state == WAIT) | (state == DISCARD);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail] <= {fpc, rom_data};
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= STOP;
            fpc   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            fpc   <= start ? '0 : redirect_target;
            // An in-flight request must be drained before the new target is fetched.
            case (state)
                STOP:          state <= start ? IDLE : STOP;
                IDLE:          state <= IDLE;
                WAIT, DISCARD: state <= rom_valid ? IDLE : DISCARD;
                default:       state <= STOP;
            endcase
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case (state)
                STOP: state <= STOP;
                IDLE: begin
                    if (rom_req) begin
                        state <= WAIT;
                    end else if (halt) begin
                        state <= STOP;
                    end
                end
                WAIT: begin
                    if (rom_valid) begin
                        fpc   <= fpc + AW'(1);
                        state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (rom_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= STOP;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_prefetch.sv
// tb/tb_inst_prefetch.sv - randomized and directed bench for inst_prefetch against a queue model
module tb_inst_prefetch;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_target = 16'h0;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_valid = 1'b0;
    logic [8:0]  rom_data = 9'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [8:0]  instr_out;
    logic [15:0] instr_pc;
    logic [2:0]  fill;
    logic        busy;

    always #5 CLK = ~CLK;

    inst_prefetch dut (
        .CLK             (CLK),
        .reset_n         (reset_n),
        .start           (start),
        .halt            (halt),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .rom_req         (rom_req),
        .rom_addr        (rom_addr),
        .rom_valid       (rom_valid),
        .rom_data        (rom_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .fill            (fill),
        .busy            (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of fetched {pc, instr} plus request bookkeeping.
    int q_pc[$];
    int q_ins[$];
    int popped[$];
    int m_fpc;
    bit m_out;
    bit m_stale;
    bit m_stop;

    // ROM responder.
    int          rom_cnt = 0;
    int          lat = 1;
    logic [15:0] pend_addr = 16'h0;
    bit          req_seen;
    logic [15:0] addr_seen;
    bit          found;
    int          r;

    function automatic logic [8:0] dat(input logic [15:0] a);
        return a[8:0] ^ {a[15:9], 2'b10};
    endfunction

    function automatic bit exp_req();
        return !m_out && !m_stop && (q_pc.size() < DEPTH) && !halt && !redirect && !start;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_ins.delete();
        m_fpc   = 0;
        m_out   = 0;
        m_stale = 0;
        m_stop  = 1;
    endtask

    task automatic model_flush(input int target);
        q_pc.delete();
        q_ins.delete();
        m_fpc = target;
        if (m_out) begin
            if (rom_valid) begin
                m_out   = 0;
                m_stale = 0;
            end else begin
                m_stale = 1;
            end
        end
    endtask

    task automatic model_update();
        bit pop;
        bit er;
        pop = (q_pc.size() > 0) && instr_ready;
        er  = exp_req();
        if (pop) popped.push_back(q_pc[0]);
        if (start) begin
            model_flush(0);
            m_stop = 0;
        end else if (redirect) begin
            model_flush(int'(redirect_target));
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (m_out && rom_valid) begin
                if (!m_stale) begin
                    q_pc.push_back(m_fpc);
                    q_ins.push_back(int'(dat(16'(m_fpc))));
                    m_fpc = (m_fpc + 1) % 65536;
                end
                m_out   = 0;
                m_stale = 0;
            end else if (er) begin
                m_out   = 1;
                m_stale = 0;
            end else if (!m_out && !m_stop && halt) begin
                m_stop = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("rom_req", rom_req, exp_req());
        chk("rom_addr", rom_addr, m_fpc);
        chk("instr_valid", instr_valid, q_pc.size() != 0);
        chk("fill", fill, q_pc.size());
        chk("busy", busy, m_out);
        if (q_pc.size() > 0) begin
            chk("instr_pc", instr_pc, q_pc[0]);
            chk("instr_out", instr_out, q_ins[0]);
        end
        if (!reset_n) begin
            chk("rst_instr_pc", instr_pc, 0);
            chk("rst_instr_out", instr_out, 0);
        end
    endtask

    // Called at a negedge with the cycle's inputs already driven.
    task automatic cycle();
        if (!reset_n) model_reset();
        rom_valid = (rom_cnt == 1);
        rom_data  = rom_valid ? dat(pend_addr) : 9'($urandom);
        #1;
        check_outputs();
        req_seen  = rom_req;
        addr_seen = rom_addr;
        @(posedge CLK);
        if (!reset_n) model_reset();
        else model_update();
        if (rom_cnt > 0) rom_cnt--;
        if (req_seen) begin
            rom_cnt   = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
            pend_addr = addr_seen;
        end
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        @(negedge CLK);
        repeat (2) cycle();
        chk("reset_rom_req", rom_req, 0);
        chk("reset_fill", fill, 0);
        reset_n = 1'b1;
        cycle();

        // Streaming with a 1-cycle ROM and decode always ready.
        lat = 1;
        instr_ready = 1'b1;
        popped.delete();
        pulse_start();
        repeat (12) cycle();
        chk("stream_pops", popped.size() >= 3, 1);
        if (popped.size() >= 3) begin
            chk("stream_pc0", popped[0], 0);
            chk("stream_pc1", popped[1], 1);
            chk("stream_pc2", popped[2], 2);
        end

        // Backpressure fills the queue, one pop frees a slot.
        instr_ready = 1'b0;
        pulse_start();
        repeat (12) cycle();
        #1;
        chk("full_fill", fill, 4);
        chk("full_no_req", rom_req, 0);
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        #1;
        chk("after_pop_fill", fill, 3);
        chk("after_pop_req", rom_req, 1);
        chk("after_pop_addr", rom_addr, 16'h0004);
        repeat (4) cycle();

        // Redirect while a slow request is in flight.
        lat = 3;
        pulse_start();
        cycle();
        redirect = 1'b1;
        redirect_target = 16'h0040;
        cycle();
        redirect = 1'b0;
        #1;
        chk("redir_busy", busy, 1);
        chk("redir_fill", fill, 0);
        found = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            #1;
            if (rom_req) begin
                found = 1;
                break;
            end
        end
        chk("redir_req_found", found, 1);
        chk("redir_addr", rom_addr, 16'h0040);
        repeat (6) cycle();

        // Redirect in the same cycle as the response.
        lat = 2;
        pulse_start();
        cycle();
        for (int k = 0; k < 8 && rom_cnt != 1; k++) cycle();
        chk("coinc_pending", rom_cnt, 1);
        redirect = 1'b1;
        redirect_target = 16'h0123;
        cycle();
        redirect = 1'b0;
        #1;
        chk("coinc_req", rom_req, 1);
        chk("coinc_addr", rom_addr, 16'h0123);
        chk("coinc_fill", fill, 0);
        chk("coinc_busy", busy, 0);
        repeat (6) cycle();

        // PC wraps from FFFF to 0.
        lat = 1;
        pulse_start();
        redirect = 1'b1;
        redirect_target = 16'hFFFF;
        cycle();
        redirect = 1'b0;
        repeat (8) cycle();
        #1;
        chk("wrap_pc_ffff", instr_pc, 16'hFFFF);
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        #1;
        chk("wrap_pc_0", instr_pc, 16'h0000);

        // Halt during WAIT: response kept, then stop until start.
        lat = 3;
        pulse_start();
        cycle();
        halt = 1'b1;
        repeat (4) cycle();
        #1;
        chk("halt_fill", fill, 1);
        halt = 1'b0;
        repeat (6) cycle();
        #1;
        chk("halt_no_req", rom_req, 0);
        chk("halt_fill_kept", fill, 1);

        // Asynchronous reset mid-request; the late response is ignored.
        pulse_start();
        cycle();
        cycle();
        reset_n = 1'b0;
        #1;
        chk("amid_rom_req", rom_req, 0);
        chk("amid_rom_addr", rom_addr, 0);
        chk("amid_valid", instr_valid, 0);
        chk("amid_fill", fill, 0);
        chk("amid_busy", busy, 0);
        chk("amid_pc", instr_pc, 0);
        chk("amid_out", instr_out, 0);
        cycle();
        reset_n = 1'b1;
        repeat (4) cycle();
        #1;
        chk("late_fill", fill, 0);
        chk("late_req", rom_req, 0);
        chk("late_busy", busy, 0);

        // Random traffic.
        lat = 0;
        pulse_start();
        for (int i = 0; i < 800; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 99));
            start = (r < 2);
            redirect = (r >= 2) && (r < 7);
            redirect_target = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            cycle();
        end
        start = 1'b0;
        redirect = 1'b0;
        halt = 1'b0;
        repeat (8) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
